// File: rtl/stdp_pkg.sv
// stdp_pkg: shared defaults, trace ceiling derivation and saturating arithmetic for the STDP neuron
package stdp_pkg;
  localparam int N_IN_DEF        = 4;
  localparam int W_WIDTH_DEF     = 8;
  localparam int V_WIDTH_DEF     = 8;
  localparam int THRESHOLD_DEF   = 128;
  localparam int LEAK_SHIFT_DEF  = 3;
  localparam int REFRACT_DEF     = 2;
  localparam int TRACE_WIDTH_DEF = 4;
  localparam int W_INIT_DEF      = 32;
  function automatic int trace_max(input int tw);
    return (1 << tw) - 1;
  endfunction
  function automatic int sat_add(input int a, input int b, input int hi);
    return (a + b > hi) ? hi : ((a + b < 0) ? 0 : a + b);
  endfunction
  function automatic int sat_sub(input int a, input int b, input int hi);
    return sat_add(a, -b, hi);
  endfunction
endpackage

// File: rtl/stdp_synapse.sv
// stdp_synapse: one weight plus its pre-synaptic trace, with pair-based LTP/LTD and host-write priority
module stdp_synapse import stdp_pkg::*; #(
  parameter int W_WIDTH     = W_WIDTH_DEF,
  parameter int TRACE_WIDTH = TRACE_WIDTH_DEF,
  parameter int W_INIT      = W_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_tick,
  input  logic                   i_learn_en,
  input  logic                   i_pre,
  input  logic                   i_fire,
  input  logic [TRACE_WIDTH-1:0] i_post_trace,
  input  logic                   i_wr_en,
  input  logic [W_WIDTH-1:0]     i_wr_data,
  output logic [W_WIDTH-1:0]     o_w
);
  localparam int TMAX = trace_max(TRACE_WIDTH);
  localparam int WMAX = (1 << W_WIDTH) - 1;
  logic [W_WIDTH-1:0]     r_w;
  logic [TRACE_WIDTH-1:0] r_trace;
  logic [TRACE_WIDTH-1:0] w_ltp;
  logic [TRACE_WIDTH-1:0] w_ltd;
  // a pre spike landing on the firing tick counts as fully causal
  always_comb begin
    w_ltp = i_fire ? (i_pre ? TRACE_WIDTH'(TMAX) : r_trace) : '0;
    w_ltd = (i_pre && i_post_trace != '0 && !i_fire) ? i_post_trace : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w     <= W_WIDTH'(W_INIT);
      r_trace <= '0;
    end else begin
      if (i_tick) r_trace <= i_pre ? TRACE_WIDTH'(TMAX) : TRACE_WIDTH'(sat_sub(int'(r_trace), 1, TMAX));
      if (i_wr_en) r_w <= i_wr_data;
      else if (i_tick && i_learn_en) r_w <= W_WIDTH'(sat_add(int'(r_w), int'(w_ltp) - int'(w_ltd), WMAX));
    end
  end
  assign o_w = r_w;
endmodule

// File: rtl/stdp_lif_neuron.sv
// stdp_lif_neuron: leaky integrate-and-fire core with refractory period, post trace and N STDP synapses
module stdp_lif_neuron import stdp_pkg::*; #(
  parameter int N_IN        = N_IN_DEF,
  parameter int W_WIDTH     = W_WIDTH_DEF,
  parameter int V_WIDTH     = V_WIDTH_DEF,
  parameter int THRESHOLD   = THRESHOLD_DEF,
  parameter int LEAK_SHIFT  = LEAK_SHIFT_DEF,
  parameter int REFRACT     = REFRACT_DEF,
  parameter int TRACE_WIDTH = TRACE_WIDTH_DEF,
  parameter int W_INIT      = W_INIT_DEF,
  localparam int SEL_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               learn_en,
  input  logic [N_IN-1:0]    pre_spike,
  output logic               spike,
  output logic [V_WIDTH-1:0] state,
  input  logic               w_wr_en,
  input  logic [SEL_W-1:0]   w_sel,
  input  logic [W_WIDTH-1:0] w_wr_data,
  output logic [W_WIDTH-1:0] w_rd_data
);
  localparam int S_W  = V_WIDTH + $clog2(N_IN) + 1;
  localparam int TMAX = trace_max(TRACE_WIDTH);
  localparam int VMAX = (1 << V_WIDTH) - 1;
  localparam int R_W  = $clog2(REFRACT + 2);
  logic [V_WIDTH-1:0]     r_v;
  logic                   r_spike;
  logic [R_W-1:0]         r_refr;
  logic [TRACE_WIDTH-1:0] r_post;
  logic [S_W-1:0]         w_sum;
  logic                   w_fire;
  logic [W_WIDTH-1:0]     w_w [N_IN];
  always_comb begin
    w_sum = S_W'(r_v) - S_W'(r_v >> LEAK_SHIFT);
    for (int i = 0; i < N_IN; i++) w_sum = w_sum + (pre_spike[i] ? S_W'(w_w[i]) : '0);
    w_fire = tick && r_refr == '0 && w_sum >= S_W'(THRESHOLD);
  end
  for (genvar g = 0; g < N_IN; g++) begin : g_syn
    stdp_synapse #(
      .W_WIDTH(W_WIDTH), .TRACE_WIDTH(TRACE_WIDTH), .W_INIT(W_INIT)
    ) u_syn (
      .clk(clk),
      .rst(rst),
      .i_tick(tick),
      .i_learn_en(learn_en),
      .i_pre(pre_spike[g]),
      .i_fire(w_fire),
      .i_post_trace(r_post),
      .i_wr_en(w_wr_en && w_sel == SEL_W'(g)),
      .i_wr_data(w_wr_data),
      .o_w(w_w[g])
    );
  end
  // refractory ticks pin v to zero and block integration
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      r_spike <= 1'b0;
      r_refr  <= '0;
      r_post  <= '0;
    end else begin
      r_spike <= w_fire;
      if (tick) begin
        r_v    <= (r_refr != '0 || w_fire) ? '0 : (w_sum > S_W'(VMAX) ? V_WIDTH'(VMAX) : V_WIDTH'(w_sum));
        r_refr <= (r_refr != '0) ? r_refr - 1'b1 : (w_fire ? R_W'(REFRACT) : '0);
        r_post <= w_fire ? TRACE_WIDTH'(TMAX) : TRACE_WIDTH'(sat_sub(int'(r_post), 1, TMAX));
      end
    end
  end
  assign spike     = r_spike;
  assign state     = r_v;
  assign w_rd_data = w_w[w_sel];
endmodule

// File: doc/stdp_lif_neuron.md
Name: stdp_lif_neuron

Overview:
Parametrised leaky integrate-and-fire neuron with N weighted synaptic inputs and on-chip pair-based STDP learning. Pre-synaptic spikes are integrated through per-synapse weights. Pre and post traces drive long-term potentiation (LTP) and depression (LTD) of the weights. It sits between the pin-level top wrapper and the input switches, and exposes membrane state, spike output and a weight read/write port.

Parameters:
N_IN, 4, number of synaptic inputs
W_WIDTH, 8, weight width (unsigned)
V_WIDTH, 8, membrane potential width (unsigned)
THRESHOLD, 128, fire when integrated potential >= THRESHOLD
LEAK_SHIFT, 3, leak per tick = v >> LEAK_SHIFT
REFRACT, 2, refractory ticks after a spike
TRACE_WIDTH, 4, trace width; TRACE_MAX = 2^TRACE_WIDTH-1
W_INIT, 32, reset value of every weight

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
tick  in  1  time-step enable; all neuron/trace/learning state advances only when high
learn_en  in  1  enables STDP weight updates
pre_spike  in  N_IN  pre-synaptic spikes, sampled on tick
spike  out  1  registered post-synaptic spike, high for exactly one cycle
state  out  V_WIDTH  membrane potential v
w_wr_en  in  1  host weight write
w_sel  in  clog2(N_IN)  weight index for write and read
w_wr_data  in  W_WIDTH  write data
w_rd_data  out  W_WIDTH  combinational read of w[w_sel]

Behaviour:
- Reset (rst=1 at a clk edge): v=0, spike=0, refractory counter=0, all pre_trace and post_trace=0, all w=W_INIT.
- tick=0: all state holds; spike=0; host writes still apply.
- On each tick, not refractory:
  - sum = v - (v>>LEAK_SHIFT) + sum of w[i] over i where pre_spike[i]=1.
  - sum uses V_WIDTH+clog2(N_IN)+1 bits.
  - If sum >= THRESHOLD: spike<=1, v<=0, refractory counter<=REFRACT.
  - Otherwise v<=min(sum, 2^V_WIDTH-1) and spike<=0.
- On a tick while refractory (counter>0): v held at 0, inputs not integrated, counter decrements, spike<=0.
- Traces, every tick:
  - pre_trace[i] <= TRACE_MAX if pre_spike[i], else saturating decrement to 0.
  - post_trace <= TRACE_MAX if firing this tick, else saturating decrement.
- STDP, on a tick with learn_en=1. All terms use trace values from before this tick's update.
  - LTP: if firing this tick, ltp[i] = pre_trace[i]. If pre_spike[i] arrives on the same tick, ltp[i] = TRACE_MAX (counted as causal).
  - LTD: if pre_spike[i] and post_trace>0 and not firing this tick, ltd[i] = post_trace.
  - Update: w[i] <= clamp(w[i] + ltp[i] - ltd[i], 0, 2^W_WIDTH-1).
  - LTD still applies during refractory ticks.
- Host write: w_wr_en writes w[w_sel] on any cycle. It takes priority over a learning update to the same synapse in the same cycle; other synapses learn normally.
- Latency: spike and state reflect the tick of the preceding clock edge (1 cycle).
- Reset mid-operation discards all pending refractory and trace state.

Decomposition:
- Shared package stdp_pkg holds:
  - the saturating add/sub helper functions;
  - the TRACE_MAX constant derivation;
  - the default parameter values shared with the top wrapper.
- One sub-module, stdp_synapse (instantiated N_IN times), holds w[i] and pre_trace[i], computes ltp/ltd and handles host-write priority.
- The neuron core (v, refractory counter, post_trace, adder tree) stays in stdp_lif_neuron.

Test Plan:
- Reset: assert rst one cycle -> spike=0, state=0, w_rd_data=32 for w_sel 0..3.
- Integration, learn_en=0, pre_spike=4'b0001 every tick -> state 32, 60, 85, 107, 126; spike on 6th tick with state=0; state stays 0 for 2 refractory ticks even with input.
- LTP, learn_en=1, w1 preset to 200 via host write:
  - stimulus: pre on ch0 at tick t; pre on ch1 at t+3.
  - response: spike at t+3; w0=32+13=45; w1=200+15=215 (simultaneous counts as LTP).
- LTD, following a spike at tick p, learn_en=1:
  - stimulus: pre on ch2 at p+2 (refractory tick).
  - response: w2=32-14=18; ch3 with pre at p+20 unchanged (post_trace=0).
- Saturation:
  - w0=250 with pre_trace 15 at post spike -> w0=255.
  - w2=5 with LTD 14 -> w2=0.
  - all weights 255 with all pre spikes -> sum 1020 handled, single spike.
- Hold/priority/reset:
  - tick=0 for 10 cycles -> state, traces and weights unchanged.
  - w_wr_en to ch0 in the LTP cycle -> w0=w_wr_data.
  - rst mid-refractory -> next tick integrates immediately.
